// File: rtl/cache_pkg.sv
// Shared types and constants for the cache-to-memory arbiter.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    RESP     = 2'd2
  } state_t;

  localparam int IBLOCK_W = 128;
  localparam int DBLOCK_W = 64;
  localparam int LINE_OFF = 4;

  // Requester IDs; also the encoding of the round-robin `last` pointer.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Align an address down to the start of its 16-byte line.
  function automatic logic [31:0] line_addr(input logic [31:0] addr);
    return {addr[31:LINE_OFF], {LINE_OFF{1'b0}}};
  endfunction

  // Align an address down to the start of its 32-bit word.
  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant. Purely combinational; the caller
// owns the `last` register and updates it when a grant is taken.
module rr_arb2
  import cache_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  // A lone requester always wins; on a tie the one that did not go last wins.
  always_comb begin
    gnt_valid = req_i | req_d;
    gnt_id    = REQ_I;
    if (req_i && req_d) begin
      gnt_id = (last == REQ_I) ? REQ_D : REQ_I;
    end else if (req_d) begin
      gnt_id = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between iCache refills and dCache
// refills/word writes. One transaction at a time, round-robin on ties,
// registered outputs, sticky err when memory is slower than TIMEOUT.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no transaction; arbitrate pending requests, latch winner
// MEM_WAIT | mem_req held high with stable addr/we/wdata; waiting ack
// RESP     | grantee's ready is high for this one cycle
module mem_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                i_req,
  input  logic [31:0]         i_addr,
  output logic                i_ready,
  output logic [IBLOCK_W-1:0] i_data,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [31:0]         d_addr,
  input  logic [31:0]         d_wdata,
  output logic                d_ready,
  output logic [DBLOCK_W-1:0] d_data,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic                mem_ack,
  input  logic [127:0]        mem_rdata,
  output logic                err
);

  // Counter saturates at TIMEOUT so a very slow memory never wraps it.
  localparam int unsigned    CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic             last_q;
  logic             gnt_q;
  logic             d_hi_q;
  logic [CNT_W-1:0] cnt_q;
  logic             gnt_valid, gnt_id;

  // Offset bits below the line/word boundary are dropped by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[LINE_OFF-1:0], d_addr[1:0]};

  rr_arb2 u_rr_arb2 (
    .req_i     (i_req),
    .req_d     (d_req),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (gnt_valid) state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ack)   state_d = RESP;
      RESP:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Registered datapath: grant latch, memory handshake, data capture,
  // ready pulses and timeout tracking, all keyed off the current state.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      last_q    <= REQ_I;
      gnt_q     <= REQ_I;
      d_hi_q    <= 1'b0;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_data    <= '0;
      d_data    <= '0;
      err       <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            gnt_q   <= gnt_id;
            last_q  <= gnt_id;
            cnt_q   <= '0;
            mem_req <= 1'b1;
            if (gnt_id == REQ_D) begin
              d_hi_q    <= d_addr[3];
              mem_we    <= d_we;
              mem_addr  <= d_we ? word_addr(d_addr) : line_addr(d_addr);
              mem_wdata <= d_we ? d_wdata : 32'h0;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= line_addr(i_addr);
              mem_wdata <= 32'h0;
            end
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (gnt_q == REQ_I) begin
              i_data  <= mem_rdata;
              i_ready <= 1'b1;
            end else begin
              // A completed write leaves the last refill block in place.
              if (!mem_we) begin
                d_data <= d_hi_q ? mem_rdata[127:64] : mem_rdata[63:0];
              end
              d_ready <= 1'b1;
            end
          end else begin
            if (cnt_q != TO_VAL) begin
              cnt_q <= cnt_q + 1'b1;
            end
            // err rises on the same edge that carries the counter to TIMEOUT.
            if (cnt_q == TO_VAL - 1'b1) begin
              err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
